id_ctrl_stage: RTL and testbench
================================

ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

Interface
REQ-001 Parameter ALUOP_W, default 5: width of alu_op; encodings occupy the low bits, upper bits zero.
REQ-002 Parameter DIV_LAT, default 8, range 1..32: total cycles a DIV/DIVU/REM/REMU occupies the stage.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  instr holds a valid fetched instruction.
REQ-006 in_ready  out  1  stage accepts instr this cycle.
REQ-007 instr  in  32  raw RV32 instruction.
REQ-008 ex_mem_read  in  1  instruction currently in EX is a load.
REQ-009 ex_rd  in  5  destination register of that EX instruction.
REQ-010 flush  in  1  discard the held output and any in-progress divide.
REQ-011 out_valid  out  1  control bundle valid.
REQ-012 out_ready  in  1  downstream consumes the bundle.
REQ-013 reg_write, mem_write, alu_src  out  1 each  registered control bits.
REQ-014 ext_op  out  6  one-hot immediate type: [5] shamt, [4] I, [3] S, [2] B, [1] U, [0] J.
REQ-015 alu_op  out  ALUOP_W;  npc_op  out  3;  gpr_sel  out  2;  wd_sel  out  2;  dm_type  out  3; encodings per ctrl_encode_def.v.
REQ-016 illegal  out  1  held instruction is not a decodable RV32I (or M, if enabled) instruction.

Function
REQ-017 Decode is combinational from instr; all outputs registered; decode-to-out_valid latency exactly 1 cycle.
REQ-018 Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-019 in_ready = ~busy & ~hazard & (~out_valid | out_ready).
REQ-020 hazard = in_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == rs1, or ex_rd == rs2 for R/S/B formats); while hazard holds, output register loads a bubble (out_valid=0) if it would otherwise be consumed or empty.
REQ-021 Field decode: LUI, AUIPC, JAL, JALR, loads, stores, branches, OP-IMM, OP; funct7 checked for R-type and shift-immediates; any other opcode/funct combination sets illegal=1 with reg_write=0, mem_write=0, npc_op=PLUS4, out_valid=1.
REQ-022 gpr_sel = GPRSel_31 only for JAL with rd=x1... no: gpr_sel = GPRSel_RD for all, except GPRSel_31 for JAL.
REQ-023 dm_type derived from funct3 only for loads/stores; dm_word otherwise.
REQ-024 Any instruction with rd=x0 forces reg_write=0.
REQ-025 State machine: IDLE (no valid output), HOLD (out_valid=1, awaiting out_ready), DIV (busy countdown).
REQ-026 IDLE->HOLD on accept; HOLD->HOLD on accept+consume same cycle; HOLD->IDLE on consume without accept; accept of a divide enters DIV.
REQ-027 DIV: counter loads DIV_LAT-1, decrements per cycle, busy=1, out_valid=0; at zero -> HOLD with the divide's bundle valid.
REQ-028 flush wins over all: next cycle out_valid=0, busy=0, state IDLE; instr presented with flush is not accepted (in_ready=0 during flush).
REQ-029 Output registers hold value while out_valid & ~out_ready (no change under stall).

Reset
REQ-030 rst synchronous, active-high, dominates flush and all handshakes.
REQ-031 After reset: state IDLE, out_valid=0, busy=0, counter=0, illegal=0, reg_write=0, mem_write=0, alu_src=0, ext_op=0, alu_op=ALUOp_add, npc_op=NPC_PLUS4, gpr_sel=GPRSel_RD, wd_sel=WDSel_FromALU, dm_type=dm_word.
REQ-032 in_ready=0 during the reset cycle.

Configuration
REQ-033 Macro CTRL_MEXT_EN defined: OP with funct7=0000001 decodes as MUL/MULH/MULHSU/MULHU (1-cycle) and DIV/DIVU/REM/REMU (DIV state), alu_op from the M encodings.
REQ-034 CTRL_MEXT_EN undefined: funct7=0000001 is illegal; DIV state and counter absent; busy tied 0.

Verification
REQ-035 Reset then instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_src=1, ext_op=010000, alu_op=ALUOp_add.
REQ-036 ex_mem_read=1, ex_rd=2, instr=0x002081B3 (add x3,x1,x2) -> in_ready=0, out_valid=0 one cycle; ex_mem_read=0 -> accepted, bundle next cycle.
REQ-037 Hold out_ready=0 three cycles with sw (0x0020A223) held -> mem_write=1, dm_type=dm_word stable, in_ready=0 throughout.
REQ-038 instr=0xFFFFFFFF -> out_valid=1, illegal=1, reg_write=0, mem_write=0.
REQ-039 With CTRL_MEXT_EN, DIV_LAT=8, div (0x0220C1B3) -> in_ready=0 and out_valid=0 for 8 cycles, then out_valid=1; repeat with flush in cycle 3 -> out_valid stays 0, in_ready=1 next cycle.
REQ-040 Without CTRL_MEXT_EN, instr=0x022081B3 (mul) -> illegal=1, in_ready returns 1 after one cycle.

Source files
------------

// File: rtl/id_ctrl_stage_if.sv
// id_ctrl_stage_if: handshake and control-bundle bus of the decode/control stage.
// slave  = the stage itself, master = whoever feeds instructions and drains bundles.
interface id_ctrl_stage_if #(
  parameter int ALUOP_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instr;
  logic               ex_mem_read;
  logic [4:0]         ex_rd;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic               reg_write;
  logic               mem_write;
  logic               alu_src;
  logic [5:0]         ext_op;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         npc_op;
  logic [1:0]         gpr_sel;
  logic [1:0]         wd_sel;
  logic [2:0]         dm_type;
  logic               illegal;

  modport master (
    output in_valid, instr, ex_mem_read, ex_rd, flush, out_ready,
    input  in_ready, out_valid, reg_write, mem_write, alu_src, ext_op,
           alu_op, npc_op, gpr_sel, wd_sel, dm_type, illegal
  );

  modport slave (
    input  in_valid, instr, ex_mem_read, ex_rd, flush, out_ready,
    output in_ready, out_valid, reg_write, mem_write, alu_src, ext_op,
           alu_op, npc_op, gpr_sel, wd_sel, dm_type, illegal
  );
endinterface

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: RV32I decode/control stage with a one-entry registered output,
// load-use hazard bubbling and an optional multi-cycle divide hold.
// Optional feature: define CTRL_MEXT_EN to decode the M extension; divides then
// occupy the stage for DIV_LAT cycles before their bundle becomes valid.
module id_ctrl_stage #(
  parameter int ALUOP_W = 5,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  id_ctrl_stage_if.slave  bus
);

  // Opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Control encodings shared with the datapath
  localparam logic [4:0] ALUOp_lui    = 5'b00001;
  localparam logic [4:0] ALUOp_auipc  = 5'b00010;
  localparam logic [4:0] ALUOp_add    = 5'b00011;
  localparam logic [4:0] ALUOp_sub    = 5'b00100;
  localparam logic [4:0] ALUOp_bne    = 5'b00101;
  localparam logic [4:0] ALUOp_blt    = 5'b00110;
  localparam logic [4:0] ALUOp_bge    = 5'b00111;
  localparam logic [4:0] ALUOp_bltu   = 5'b01000;
  localparam logic [4:0] ALUOp_bgeu   = 5'b01001;
  localparam logic [4:0] ALUOp_slt    = 5'b01010;
  localparam logic [4:0] ALUOp_sltu   = 5'b01011;
  localparam logic [4:0] ALUOp_xor    = 5'b01100;
  localparam logic [4:0] ALUOp_or     = 5'b01101;
  localparam logic [4:0] ALUOp_and    = 5'b01110;
  localparam logic [4:0] ALUOp_sll    = 5'b01111;
  localparam logic [4:0] ALUOp_srl    = 5'b10000;
  localparam logic [4:0] ALUOp_sra    = 5'b10001;
`ifdef CTRL_MEXT_EN
  localparam logic [4:0] ALUOp_mul    = 5'b10010;
  localparam logic [4:0] ALUOp_mulh   = 5'b10011;
  localparam logic [4:0] ALUOp_mulhsu = 5'b10100;
  localparam logic [4:0] ALUOp_mulhu  = 5'b10101;
  localparam logic [4:0] ALUOp_div    = 5'b10110;
  localparam logic [4:0] ALUOp_divu   = 5'b10111;
  localparam logic [4:0] ALUOp_rem    = 5'b11000;
  localparam logic [4:0] ALUOp_remu   = 5'b11001;
`endif
  localparam logic [2:0] NPC_PLUS4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH   = 3'b001;
  localparam logic [2:0] NPC_JUMP     = 3'b010;
  localparam logic [2:0] NPC_JALR     = 3'b100;
  localparam logic [1:0] GPRSel_RD    = 2'b00;
  localparam logic [1:0] GPRSel_31    = 2'b10;
  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;
  localparam logic [2:0] dm_word      = 3'b000;
  localparam logic [2:0] dm_halfword  = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte      = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;
  localparam logic [5:0] EXT_SHAMT    = 6'b100000;
  localparam logic [5:0] EXT_I        = 6'b010000;
  localparam logic [5:0] EXT_S        = 6'b001000;
  localparam logic [5:0] EXT_B        = 6'b000100;
  localparam logic [5:0] EXT_U        = 6'b000010;
  localparam logic [5:0] EXT_J        = 6'b000001;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b01;
`ifdef CTRL_MEXT_EN
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [4:0] CNT_LOAD = 5'(DIV_LAT - 1);
`endif

  if (DIV_LAT < 1 || DIV_LAT > 32) begin : g_bad_div_lat
    $error("id_ctrl_stage: DIV_LAT must be within 1..32");
  end

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [5:0] ext_op;
    logic [4:0] alu_op;
    logic [2:0] npc_op;
    logic [1:0] gpr_sel;
    logic [1:0] wd_sel;
    logic [2:0] dm_type;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{illegal: 1'b0, reg_write: 1'b0, mem_write: 1'b0,
                                 alu_src: 1'b0, ext_op: 6'b0, alu_op: ALUOp_add,
                                 npc_op: NPC_PLUS4, gpr_sel: GPRSel_RD,
                                 wd_sel: WDSel_FromALU, dm_type: dm_word};

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = bus.instr[6:0];
  assign rd  = bus.instr[11:7];
  assign f3  = bus.instr[14:12];
  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign f7  = bus.instr[31:25];

  ctrl_t dec;
  logic  dec_ok, uses_rs2;
`ifdef CTRL_MEXT_EN
  logic  dec_div;
`endif

  // Combinational field decode of the instruction presented to the stage
  always_comb begin
    dec      = CTRL_RST;
    dec_ok   = 1'b1;
    uses_rs2 = 1'b0;
`ifdef CTRL_MEXT_EN
    dec_div  = 1'b0;
`endif
    case (opc)
      OPC_LUI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_U; dec.alu_op = ALUOp_lui;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_U; dec.alu_op = ALUOp_auipc;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1; dec.ext_op = EXT_J; dec.npc_op = NPC_JUMP;
        dec.gpr_sel = GPRSel_31; dec.wd_sel = WDSel_FromPC;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
        dec.npc_op = NPC_JALR; dec.wd_sel = WDSel_FromPC;
        dec_ok = (f3 == 3'b000);
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I; dec.wd_sel = WDSel_FromMEM;
        case (f3)
          3'b000:  dec.dm_type = dm_byte;
          3'b001:  dec.dm_type = dm_halfword;
          3'b010:  dec.dm_type = dm_word;
          3'b100:  dec.dm_type = dm_byte_unsigned;
          3'b101:  dec.dm_type = dm_halfword_unsigned;
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        uses_rs2 = 1'b1;
        dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_S;
        case (f3)
          3'b000:  dec.dm_type = dm_byte;
          3'b001:  dec.dm_type = dm_halfword;
          3'b010:  dec.dm_type = dm_word;
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        uses_rs2 = 1'b1;
        dec.ext_op = EXT_B; dec.npc_op = NPC_BRANCH;
        case (f3)
          3'b000:  dec.alu_op = ALUOp_sub;   // beq: compare by subtraction
          3'b001:  dec.alu_op = ALUOp_bne;
          3'b100:  dec.alu_op = ALUOp_blt;
          3'b101:  dec.alu_op = ALUOp_bge;
          3'b110:  dec.alu_op = ALUOp_bltu;
          3'b111:  dec.alu_op = ALUOp_bgeu;
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
        case (f3)
          3'b000: dec.alu_op = ALUOp_add;
          3'b010: dec.alu_op = ALUOp_slt;
          3'b011: dec.alu_op = ALUOp_sltu;
          3'b100: dec.alu_op = ALUOp_xor;
          3'b110: dec.alu_op = ALUOp_or;
          3'b111: dec.alu_op = ALUOp_and;
          3'b001: begin
            dec.ext_op = EXT_SHAMT; dec.alu_op = ALUOp_sll;
            dec_ok = (f7 == 7'b0000000);
          end
          default: begin
            dec.ext_op = EXT_SHAMT;
            if (f7 == 7'b0000000)      dec.alu_op = ALUOp_srl;
            else if (f7 == 7'b0100000) dec.alu_op = ALUOp_sra;
            else                       dec_ok = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_op = ALUOp_add;
            3'b001:  dec.alu_op = ALUOp_sll;
            3'b010:  dec.alu_op = ALUOp_slt;
            3'b011:  dec.alu_op = ALUOp_sltu;
            3'b100:  dec.alu_op = ALUOp_xor;
            3'b101:  dec.alu_op = ALUOp_srl;
            3'b110:  dec.alu_op = ALUOp_or;
            default: dec.alu_op = ALUOp_and;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec.alu_op = ALUOp_sub;
          else if (f3 == 3'b101) dec.alu_op = ALUOp_sra;
          else                   dec_ok = 1'b0;
        end
`ifdef CTRL_MEXT_EN
        else if (f7 == 7'b0000001) begin
          dec_div = f3[2];
          case (f3)
            3'b000:  dec.alu_op = ALUOp_mul;
            3'b001:  dec.alu_op = ALUOp_mulh;
            3'b010:  dec.alu_op = ALUOp_mulhsu;
            3'b011:  dec.alu_op = ALUOp_mulhu;
            3'b100:  dec.alu_op = ALUOp_div;
            3'b101:  dec.alu_op = ALUOp_divu;
            3'b110:  dec.alu_op = ALUOp_rem;
            default: dec.alu_op = ALUOp_remu;
          endcase
        end
`endif
        else dec_ok = 1'b0;
      end
      default: dec_ok = 1'b0;
    endcase
    // Undecodable: a harmless fall-through bundle flagged illegal
    if (!dec_ok) begin
      dec = CTRL_RST;
      dec.illegal = 1'b1;
`ifdef CTRL_MEXT_EN
      dec_div = 1'b0;
`endif
    end
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

  logic [1:0] state_q, state_d;
  logic       out_valid_q, out_valid_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       busy, hazard, in_ready, accept;
`ifdef CTRL_MEXT_EN
  logic [4:0] cnt_q, cnt_d;
  assign busy = (state_q == S_DIV);
`else
  assign busy = 1'b0;
`endif

  // Load-use: rs1 always compared, rs2 only where the format reads it
  assign hazard   = bus.in_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((bus.ex_rd == rs1) | (uses_rs2 & (bus.ex_rd == rs2)));
  assign in_ready = ~rst & ~bus.flush & ~busy & ~hazard & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Next-state: flush first, then divide countdown, then accept/consume
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
`ifdef CTRL_MEXT_EN
    cnt_d       = cnt_q;
`endif
    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
`ifdef CTRL_MEXT_EN
      cnt_d       = 5'd0;
`endif
    end
`ifdef CTRL_MEXT_EN
    else if (state_q == S_DIV) begin
      if (cnt_q == 5'd0) begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
`endif
    else if (accept) begin
      ctrl_d      = dec;
      state_d     = S_HOLD;
      out_valid_d = 1'b1;
`ifdef CTRL_MEXT_EN
      if (dec_div) begin
        state_d     = S_DIV;
        out_valid_d = 1'b0;
        cnt_d       = CNT_LOAD;
      end
`endif
    end else if (out_valid_q & bus.out_ready) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_RST;
`ifdef CTRL_MEXT_EN
      cnt_q       <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
`ifdef CTRL_MEXT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.illegal   = ctrl_q.illegal;
  assign bus.reg_write = ctrl_q.reg_write;
  assign bus.mem_write = ctrl_q.mem_write;
  assign bus.alu_src   = ctrl_q.alu_src;
  assign bus.ext_op    = ctrl_q.ext_op;
  assign bus.alu_op    = ALUOP_W'(ctrl_q.alu_op);
  assign bus.npc_op    = ctrl_q.npc_op;
  assign bus.gpr_sel   = ctrl_q.gpr_sel;
  assign bus.wd_sel    = ctrl_q.wd_sel;
  assign bus.dm_type   = ctrl_q.dm_type;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: directed scenarios then randomized traffic, every cycle
// compared against a table-driven instruction model and a transaction-level
// occupancy model of the stage.
module tb_id_ctrl_stage;
  localparam int DIV_LAT = 8;
`ifdef CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [4:0] A_LUI = 5'd1, A_AUIPC = 5'd2, A_ADD = 5'd3, A_SUB = 5'd4,
    A_BNE = 5'd5, A_BLT = 5'd6, A_BGE = 5'd7, A_BLTU = 5'd8, A_BGEU = 5'd9,
    A_SLT = 5'd10, A_SLTU = 5'd11, A_XOR = 5'd12, A_OR = 5'd13, A_AND = 5'd14,
    A_SLL = 5'd15, A_SRL = 5'd16, A_SRA = 5'd17, A_MUL = 5'd18, A_MULH = 5'd19,
    A_MULHSU = 5'd20, A_MULHU = 5'd21, A_DIV = 5'd22, A_DIVU = 5'd23,
    A_REM = 5'd24, A_REMU = 5'd25;
  localparam logic [2:0] NPC_P4 = 3'b000, NPC_BR = 3'b001, NPC_J = 3'b010, NPC_JR = 3'b100;
  localparam logic [1:0] GPR_RD = 2'b00, GPR_31 = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;
  localparam logic [2:0] DM_W = 3'd0, DM_H = 3'd1, DM_HU = 3'd2, DM_B = 3'd3, DM_BU = 3'd4;

  typedef struct packed {
    logic       illegal, reg_write, mem_write, alu_src;
    logic [5:0] ext_op;
    logic [4:0] alu_op;
    logic [2:0] npc_op;
    logic [1:0] gpr_sel, wd_sel;
    logic [2:0] dm_type;
  } bund_t;

  localparam bund_t RST_B = '{illegal: 1'b0, reg_write: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
                              ext_op: 6'b0, alu_op: A_ADD, npc_op: NPC_P4, gpr_sel: GPR_RD,
                              wd_sel: WD_ALU, dm_type: DM_W};

  // Lookup tables indexed by funct3
  logic [4:0] op_alu [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  logic [4:0] br_alu [8] = '{A_SUB, A_BNE, A_ADD, A_ADD, A_BLT, A_BGE, A_BLTU, A_BGEU};
  logic [4:0] m_alu  [8] = '{A_MUL, A_MULH, A_MULHSU, A_MULHU, A_DIV, A_DIVU, A_REM, A_REMU};
  logic [2:0] mem_dm [8] = '{DM_B, DM_H, DM_W, DM_W, DM_BU, DM_HU, DM_W, DM_W};
  logic [7:0] ld_ok = 8'b0011_0111;
  logic [7:0] st_ok = 8'b0000_0111;
  logic [7:0] br_ok = 8'b1111_0011;
  logic [6:0] opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ctrl_stage_if #(.ALUOP_W(5)) bus ();
  id_ctrl_stage #(.ALUOP_W(5), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: classify by opcode, then pull fields from tables
  function automatic bund_t ref_decode(input logic [31:0] ins);
    bund_t b;
    logic ok, shift, alt;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    b = RST_B; ok = 1'b1;
    case (opc)
      7'h37: begin b.reg_write = 1; b.alu_src = 1; b.ext_op = 6'b000010; b.alu_op = A_LUI; end
      7'h17: begin b.reg_write = 1; b.alu_src = 1; b.ext_op = 6'b000010; b.alu_op = A_AUIPC; end
      7'h6F: begin b.reg_write = 1; b.ext_op = 6'b000001; b.npc_op = NPC_J; b.gpr_sel = GPR_31; b.wd_sel = WD_PC; end
      7'h67: begin b.reg_write = 1; b.alu_src = 1; b.ext_op = 6'b010000; b.npc_op = NPC_JR; b.wd_sel = WD_PC; ok = (f3 == 0); end
      7'h03: begin b.reg_write = 1; b.alu_src = 1; b.ext_op = 6'b010000; b.wd_sel = WD_MEM; b.dm_type = mem_dm[f3]; ok = ld_ok[f3]; end
      7'h23: begin b.mem_write = 1; b.alu_src = 1; b.ext_op = 6'b001000; b.dm_type = mem_dm[f3]; ok = st_ok[f3]; end
      7'h63: begin b.ext_op = 6'b000100; b.npc_op = NPC_BR; b.alu_op = br_alu[f3]; ok = br_ok[f3]; end
      7'h13: begin
        b.reg_write = 1; b.alu_src = 1;
        shift = (f3 == 1) || (f3 == 5);
        alt = (f3 == 5) && (f7 == 7'h20);
        b.ext_op = shift ? 6'b100000 : 6'b010000;
        b.alu_op = alt ? A_SRA : op_alu[f3];
        ok = !shift || (f7 == 0) || alt;
      end
      7'h33: begin
        b.reg_write = 1;
        if (f7 == 0) b.alu_op = op_alu[f3];
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) b.alu_op = (f3 == 0) ? A_SUB : A_SRA;
        else if (MEXT && f7 == 7'h01) b.alu_op = m_alu[f3];
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin b = RST_B; b.illegal = 1; end
    if (ins[11:7] == 0) b.reg_write = 0;
    return b;
  endfunction

  function automatic logic is_div(input logic [31:0] ins);
    return MEXT && ins[6:0] == 7'h33 && ins[31:25] == 7'h01 && ins[14];
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ins);
    return ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
  endfunction

  // Stage occupancy model: holding flag, bundle, remaining busy cycles
  logic  m_ov = 1'b0;
  bund_t m_b = RST_B;
  int    m_busy = 0;

  function automatic logic exp_rdy();
    logic hz;
    hz = bus.in_valid && bus.ex_mem_read && bus.ex_rd != 0 &&
         (bus.ex_rd == bus.instr[19:15] || (reads_rs2(bus.instr) && bus.ex_rd == bus.instr[24:20]));
    return !rst && !bus.flush && m_busy == 0 && !hz && (!m_ov || bus.out_ready);
  endfunction

  task automatic model_step();
    logic r;
    r = exp_rdy();
    if (rst) begin m_ov = 0; m_busy = 0; m_b = RST_B; end
    else if (bus.flush) begin m_ov = 0; m_busy = 0; end
    else if (m_busy > 0) begin m_busy--; if (m_busy == 0) m_ov = 1; end
    else if (bus.in_valid && r) begin
      m_b = ref_decode(bus.instr);
      if (is_div(bus.instr)) begin m_busy = DIV_LAT; m_ov = 0; end
      else m_ov = 1;
    end else if (m_ov && bus.out_ready) m_ov = 0;
  endtask

  function automatic bund_t dut_b();
    return {bus.illegal, bus.reg_write, bus.mem_write, bus.alu_src, bus.ext_op, bus.alu_op,
            bus.npc_op, bus.gpr_sel, bus.wd_sel, bus.dm_type};
  endfunction

  // One clock: inputs already applied just after a falling edge
  task automatic tick();
    #1 chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("bundle", 32'(dut_b()), 32'(m_b));
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[11:7]  = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.instr = 32'h0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.flush = 0; bus.out_ready = 1;
    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'(A_ADD));
    rst = 1'b0;

    // addi x1,x0,5
    bus.in_valid = 1; bus.instr = 32'h00500093;
    tick();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_ext", 32'(bus.ext_op), 32'b010000);
    chk("addi_regwr", 32'(bus.reg_write), 32'd1);
    chk("addi_alusrc", 32'(bus.alu_src), 32'd1);

    // load-use hazard on rs2 of add x3,x1,x2
    bus.instr = 32'h002081B3; bus.ex_mem_read = 1; bus.ex_rd = 5'd2;
    #1 chk("haz_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("haz_bubble", 32'(bus.out_valid), 32'd0);
    bus.ex_mem_read = 0;
    tick();
    chk("haz_release", 32'(bus.out_valid), 32'd1);

    // sw held under downstream stall
    bus.instr = 32'h0020A223;
    tick();
    bus.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sw_memwr", 32'(bus.mem_write), 32'd1);
      chk("sw_dm", 32'(bus.dm_type), 32'(DM_W));
      chk("sw_stall_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1;
    tick();

    // all-ones word is not an instruction
    bus.instr = 32'hFFFFFFFF;
    tick();
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_regwr", 32'(bus.reg_write), 32'd0);
    chk("ill_memwr", 32'(bus.mem_write), 32'd0);

    // mul x3,x1,x2
    bus.instr = 32'h022081B3;
    tick();
    chk("mul_illegal", 32'(bus.illegal), 32'(!MEXT));
    chk("mul_rdy", 32'(bus.in_ready), 32'd1);

`ifdef CTRL_MEXT_EN
    // div x3,x1,x2: busy for DIV_LAT cycles, then bundle
    bus.in_valid = 0;
    tick();
    bus.in_valid = 1; bus.instr = 32'h0220C1B3;
    tick();
    bus.in_valid = 0;
    for (int k = 0; k < DIV_LAT; k++) begin
      chk("div_busy_valid", 32'(bus.out_valid), 32'd0);
      chk("div_busy_rdy", 32'(bus.in_ready), 32'd0);
      tick();
    end
    chk("div_done", 32'(bus.out_valid), 32'd1);
    chk("div_alu", 32'(bus.alu_op), 32'(A_DIV));
    tick();
    // same divide, flushed in its third busy cycle
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick(); tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("div_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("div_flush_rdy", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < DIV_LAT; k++) tick();
    chk("div_flush_stays", 32'(bus.out_valid), 32'd0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.flush       = ($urandom_range(0, 29) == 0);
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.ex_mem_read = ($urandom_range(0, 2) == 0);
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.instr       = rnd_instr();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
